data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit.sv | 150 +++++++++++++++
 tb/tb_data_mem_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Data memory unit: byte-addressable word RAM, load/store alignment and access checks,
// plus a memory-mapped TX byte FIFO with a status register.
module data_mem_unit #(
    parameter int RAM_WORDS = 1024,
    parameter int TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  instType_i,
    input  logic [31:0] dataAddress_i,
    input  logic [31:0] writeData_i,
    output logic [31:0] readData_o,
    output logic [31:0] memException_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);
    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam logic [29:0] TXDATA_W  = 30'h0400_0000;
    localparam logic [29:0] TXSTAT_W  = 30'h0400_0001;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [TX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          is_load, is_store, uns;
    logic [1:0]    sz;
    logic          misalign, hit_ram, hit_txd, hit_txs, active, req_ok;
    logic [AW-1:0] ram_idx;
    logic [31:0]   raw_word, shifted, ext, txstat;
    logic [31:0]   wr_word;
    logic [3:0]    be;
    logic          full, empty, ram_we, push_req, do_push, do_pop;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz       = 2'd0;
        uns      = 1'b0;
        case (instType_i)
            4'b0001: begin is_load = 1'b1; sz = 2'd0; end
            4'b0010: begin is_load = 1'b1; sz = 2'd1; end
            4'b0011: begin is_load = 1'b1; sz = 2'd2; end
            4'b0100: begin is_load = 1'b1; sz = 2'd0; uns = 1'b1; end
            4'b0101: begin is_load = 1'b1; sz = 2'd1; uns = 1'b1; end
            4'b1001: begin is_store = 1'b1; sz = 2'd0; end
            4'b1010: begin is_store = 1'b1; sz = 2'd1; end
            4'b1011: begin is_store = 1'b1; sz = 2'd2; end
            default: ;
        endcase
    end

    assign active   = is_load | is_store;
    assign misalign = ((sz == 2'd1) && dataAddress_i[0]) ||
                      ((sz == 2'd2) && (dataAddress_i[1:0] != 2'b00));
    assign hit_ram  = dataAddress_i < RAM_BYTES;
    assign hit_txd  = dataAddress_i[31:2] == TXDATA_W;
    assign hit_txs  = dataAddress_i[31:2] == TXSTAT_W;

    // Misalignment outranks access fault.
    always_comb begin
        memException_o = 32'd0;
        if (active && misalign)
            memException_o = is_load ? 32'd4 : 32'd6;
        else if (active && !(hit_ram || hit_txd || hit_txs))
            memException_o = is_load ? 32'd5 : 32'd7;
    end

    assign req_ok  = active && (memException_o == 32'd0);
    assign ram_idx = dataAddress_i[AW+1:2];

    assign full   = count == CW'(TX_DEPTH);
    assign empty  = count == '0;
    assign txstat = {16'd0, 8'(count), 5'd0, overflow, empty, full};

    always_comb begin
        raw_word = 32'd0;
        if (hit_ram)
            raw_word = ram[ram_idx];
        else if (hit_txs)
            raw_word = txstat;
    end

    assign shifted = raw_word >> {dataAddress_i[1:0], 3'b000};

    always_comb begin
        ext = shifted;
        if (sz == 2'd0)
            ext = uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        else if (sz == 2'd1)
            ext = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end

    assign readData_o = (req_ok && is_load) ? ext : 32'd0;

    always_comb begin
        be      = 4'b1111;
        wr_word = writeData_i;
        if (sz == 2'd0) begin
            be      = 4'b0001 << dataAddress_i[1:0];
            wr_word = {4{writeData_i[7:0]}};
        end else if (sz == 2'd1) begin
            be      = dataAddress_i[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{writeData_i[15:0]}};
        end
    end

    assign ram_we   = !rst && req_ok && is_store && hit_ram;
    assign push_req = !rst && req_ok && is_store && hit_txd;
    assign do_push  = push_req && !full;
    assign do_pop   = !rst && !empty && tx_ready_i;

    // RAM is intentionally left out of reset so data survives a core reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[ram_idx][8*i +: 8] <= wr_word[8*i +: 8];
        end
        if (do_push)
            fifo[wr_ptr] <= writeData_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_req && full)
                overflow <= 1'b1;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    assign tx_valid_o = !empty;
    assign tx_data_o  = empty ? 8'd0 : fifo[rd_ptr];
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: byte-array RAM model and byte-queue FIFO model,
// directed scenarios followed by randomized traffic.
module tb_data_mem_unit;
    localparam int RW    = 1024;
    localparam int DEPTH = 8;
    localparam logic [31:0] TXD = 32'h1000_0000;
    localparam logic [31:0] TXS = 32'h1000_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  instType_i = '0;
    logic [31:0] dataAddress_i = '0;
    logic [31:0] writeData_i = '0;
    logic [31:0] readData_o, memException_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;

    data_mem_unit #(.RAM_WORDS(RW), .TX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instType_i(instType_i), .dataAddress_i(dataAddress_i),
        .writeData_i(writeData_i), .readData_o(readData_o), .memException_o(memException_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] exc;
        logic        vld;
        logic [7:0]  dat;
        bit          chk_rd;
        string       tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem_b [4*RW];
    logic [7:0] txq[$];
    bit         ovf = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    // Behavioural view of one access: which target it hits, size, and the expected response.
    function automatic void ref_access(input logic [3:0] t, input logic [31:0] a,
                                       output logic [31:0] rd, output logic [31:0] exc,
                                       output int tgt, output int n, output bit st, output bit ld);
        bit sgn = 1'b0;
        longint v = 0;
        logic [31:0] stat;
        ld = 1'b0; st = 1'b0; n = 0; rd = '0; exc = '0; tgt = -1;
        case (t)
            4'd1: begin ld = 1; n = 1; sgn = 1; end
            4'd2: begin ld = 1; n = 2; sgn = 1; end
            4'd3: begin ld = 1; n = 4; end
            4'd4: begin ld = 1; n = 1; end
            4'd5: begin ld = 1; n = 2; end
            4'd9: begin st = 1; n = 1; end
            4'd10: begin st = 1; n = 2; end
            4'd11: begin st = 1; n = 4; end
            default: ;
        endcase
        if (!(ld || st)) return;
        if (a < 32'(4*RW)) tgt = 0;
        else if (a >= TXD && a < TXD + 4) tgt = 1;
        else if (a >= TXS && a < TXS + 4) tgt = 2;
        else tgt = 3;
        if (a % n != 0) exc = ld ? 32'd4 : 32'd6;
        else if (tgt == 3) exc = ld ? 32'd5 : 32'd7;
        if (exc != 0) begin tgt = -1; return; end
        if (st) return;
        stat = {16'd0, 8'(txq.size()), 5'd0, ovf, txq.size() == 0, txq.size() == DEPTH};
        for (int i = 0; i < n; i++) begin
            longint b = 0;
            if (tgt == 0) b = longint'(mem_b[a + i]);
            else if (tgt == 2) b = longint'((stat >> (8 * (a - TXS + i))) & 32'hFF);
            v += b << (8 * i);
        end
        if (sgn && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
        rd = v[31:0];
    endfunction

    task automatic do_cycle(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                            input bit rdy, input bit r, input bit use_k,
                            input logic [31:0] k_rd, input logic [31:0] k_exc, input string tag);
        exp_t e;
        logic [31:0] rd, exc;
        int tgt, n;
        bit st, ld, full_pre;
        instType_i = t; dataAddress_i = a; writeData_i = wd; tx_ready_i = rdy; rst = r;
        ref_access(t, a, rd, exc, tgt, n, st, ld);
        e.rd = use_k ? k_rd : rd;
        e.exc = use_k ? k_exc : exc;
        e.vld = txq.size() != 0;
        e.dat = (txq.size() != 0) ? txq[0] : 8'd0;
        e.chk_rd = ld || (exc != 0) || !(ld || st);
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            txq.delete();
            ovf = 1'b0;
        end else begin
            full_pre = txq.size() == DEPTH;
            if (st && tgt == 0)
                for (int i = 0; i < n; i++) mem_b[a + i] = 8'((wd >> (8*i)) & 32'hFF);
            if (st && tgt == 1 && full_pre) ovf = 1'b1;
            if (txq.size() != 0 && rdy) void'(txq.pop_front());
            if (st && tgt == 1 && !full_pre) txq.push_back(wd[7:0]);
        end
        #1;
    endtask

    task automatic cyc(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                       input bit rdy, input bit r);
        do_cycle(t, a, wd, rdy, r, 1'b0, '0, '0, "model");
    endtask

    task automatic chk(input logic [3:0] t, input logic [31:0] a, input bit rdy,
                       input logic [31:0] k_rd, input logic [31:0] k_exc, input string tag);
        do_cycle(t, a, '0, rdy, 1'b0, 1'b1, k_rd, k_exc, tag);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if ((e.chk_rd && readData_o !== e.rd) || memException_o !== e.exc ||
                tx_valid_o !== e.vld || tx_data_o !== e.dat) begin
                miscompares++;
                $display("FAIL %s @%0t: rd=%h exc=%0d vld=%b dat=%h, required rd=%h exc=%0d vld=%b dat=%h",
                         e.tag, $time, readData_o, memException_o, tx_valid_o, tx_data_o,
                         e.chk_rd ? e.rd : readData_o, e.exc, e.vld, e.dat);
            end
        end
    end

    initial begin
        logic [31:0] a;
        int sel;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk(4'd0, 32'h0, 1'b0, 32'h0, 32'h0, "reset_state");

        for (int w = 0; w < 16; w++) cyc(4'd11, 32'(4*w), $urandom, 1'b0, 1'b0);
        cyc(4'd11, 32'(4*RW - 4), $urandom, 1'b0, 1'b0);

        cyc(4'd11, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        chk(4'd1, 32'h13, 1'b0, 32'hFFFFFFDE, 32'd0, "lb_sign");
        chk(4'd4, 32'h11, 1'b0, 32'h000000BE, 32'd0, "lbu_zero");
        chk(4'd2, 32'h12, 1'b0, 32'hFFFFDEAD, 32'd0, "lh_sign");
        cyc(4'd9, 32'h11, 32'h55, 1'b0, 1'b0);
        chk(4'd3, 32'h10, 1'b0, 32'hDEAD55EF, 32'd0, "sb_merge");

        chk(4'd3, 32'h2, 1'b0, 32'h0, 32'd4, "lw_misalign");
        do_cycle(4'd10, 32'h5, 32'hFFFF, 1'b0, 1'b0, 1'b1, 32'h0, 32'd6, "sh_misalign");
        cyc(4'd3, 32'h4, '0, 1'b0, 1'b0);
        chk(4'd3, 32'h2000_0000, 1'b0, 32'h0, 32'd5, "lw_fault");
        do_cycle(4'd11, 32'h2000_0000, 32'h1, 1'b0, 1'b0, 1'b1, 32'h0, 32'd7, "sw_fault");
        chk(4'd3, 32'(4*RW), 1'b0, 32'h0, 32'd5, "lw_ram_end");
        cyc(4'd3, 32'(4*RW - 4), '0, 1'b0, 1'b0);

        for (int i = 1; i <= 9; i++) cyc(4'd9, TXD, 32'(i), 1'b0, 1'b0);
        chk(4'd3, TXS, 1'b0, 32'h0000_0805, 32'd0, "txstat_full_ovf");
        chk(4'd3, TXD, 1'b0, 32'h0, 32'd0, "txdata_read_zero");
        for (int i = 0; i < 9; i++) cyc(4'd0, '0, '0, 1'b1, 1'b0);
        chk(4'd0, '0, 1'b0, 32'h0, 32'd0, "drained");

        cyc(4'd0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(4'd10, TXD, 32'hA0 + 32'(i), 1'b0, 1'b0);
        cyc(4'd11, TXD, 32'hEE, 1'b1, 1'b0);
        chk(4'd3, TXS, 1'b0, 32'h0000_0704, 32'd0, "full_push_pop");
        chk(4'd4, TXS + 1, 1'b0, 32'h0000_0007, 32'd0, "txstat_byte_lane");

        cyc(4'd0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(4'd9, TXD, 32'h30 + 32'(i), 1'b0, 1'b0);
        cyc(4'd11, 32'h10, 32'h12345678, 1'b0, 1'b1);
        chk(4'd3, TXS, 1'b0, 32'h0000_0002, 32'd0, "rst_clears_fifo");
        chk(4'd3, 32'h10, 1'b0, 32'hDEAD55EF, 32'd0, "ram_kept_on_rst");

        for (int k = 0; k < 2000; k++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) a = 32'($urandom_range(0, 63));
            else if (sel == 5) a = 32'(4*RW - 4) + 32'($urandom_range(0, 7));
            else if (sel <= 8) a = TXD + 32'($urandom_range(0, 7));
            else a = {1'b1, 31'($urandom)};
            cyc(4'($urandom_range(0, 15)), a, $urandom, $urandom_range(0, 9) < 4,
                $urandom_range(0, 199) == 0);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
